// File: rtl/inv_solver_pkg.sv
// Shared types and widths for the 2x2 inverse-matrix / vector solver.
package inv_solver_pkg;

    localparam int MAT_W     = 14;  // Q4.10 inverse-matrix word
    localparam int VEC_W     = 4;   // signed integer vector element
    localparam int OUT_W     = 19;  // Q9.10 result word
    localparam int FRAC_W    = 10;
    localparam int PROD_W    = MAT_W + VEC_W;
    localparam int MAT_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        WAIT_V,
        LOAD_V,
        CALC,
        OUT0,
        OUT1
    } state_t;

endpackage

// File: rtl/inv_solver_mac.sv
// Signed two-term dot product m0*v0 + m1*v1 at full precision (one matrix row).
module inv_solver_mac
    import inv_solver_pkg::*;
(
    input  logic signed [MAT_W-1:0] i_m0,
    input  logic signed [MAT_W-1:0] i_m1,
    input  logic signed [VEC_W-1:0] i_v0,
    input  logic signed [VEC_W-1:0] i_v1,
    output logic signed [OUT_W-1:0] o_dot
);

    logic signed [PROD_W-1:0] w_p0;
    logic signed [PROD_W-1:0] w_p1;

    // Sign-extend both operands to the product width so no bit is lost.
    assign w_p0  = PROD_W'(i_m0) * PROD_W'(i_v0);
    assign w_p1  = PROD_W'(i_m1) * PROD_W'(i_v1);
    assign o_dot = OUT_W'(w_p0) + OUT_W'(w_p1);

endmodule

// File: rtl/inv_solver.sv
// Solver top: loads inv(A) (4 words, or 1 word = singular) and v, emits x0 then x1.
// Define INV_SOLVER_KEEP_MAT_EN to retain the matrix for further vectors.
module inv_solver
    import inv_solver_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             MAT_VALID,
    input  logic [MAT_W-1:0] MAT,
    input  logic             VEC_VALID,
    input  logic [VEC_W-1:0] VEC,
    output logic             OUT_VALID,
    output logic [OUT_W-1:0] OUT,
    output logic             SINGULAR
);

    state_t                  r_state;
    state_t                  w_next;
    logic signed [MAT_W-1:0] r_mat [MAT_WORDS];
    logic [2:0]              r_cnt;
    logic                    r_singular;
    logic signed [VEC_W-1:0] r_v0;
    logic signed [VEC_W-1:0] r_v1;
    logic signed [OUT_W-1:0] r_x0;
    logic signed [OUT_W-1:0] r_x1;
    logic signed [OUT_W-1:0] w_dot0;
    logic signed [OUT_W-1:0] w_dot1;
    logic                    w_mat_start;
    logic                    w_out_valid;
    logic                    w_singular;
    logic [OUT_W-1:0]        w_out;
    logic                    r_out_valid;
    logic                    r_singular_out;
    logic [OUT_W-1:0]        r_out;

`ifdef INV_SOLVER_KEEP_MAT_EN
    localparam state_t DONE_STATE = WAIT_V;
    assign w_mat_start = MAT_VALID && (r_state == IDLE || r_state == WAIT_V);
`else
    localparam state_t DONE_STATE = IDLE;
    assign w_mat_start = MAT_VALID && (r_state == IDLE);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_mat_start) w_next = LOAD_M;
            LOAD_M:  if (!MAT_VALID)
                         w_next = (r_cnt == 3'd1 || r_cnt == 3'd4) ? WAIT_V : IDLE;
            WAIT_V:  if (w_mat_start)    w_next = LOAD_M;
                     else if (VEC_VALID) w_next = LOAD_V;
            LOAD_V:  w_next = CALC;
            CALC:    w_next = OUT0;
            OUT0:    w_next = r_singular ? DONE_STATE : OUT1;
            OUT1:    w_next = DONE_STATE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_out_valid = 1'b0;
        w_singular  = 1'b0;
        w_out       = '0;
        case (r_state)
            OUT0: begin
                w_out_valid = 1'b1;
                w_singular  = r_singular;
                if (!r_singular) w_out = r_x0;
            end
            OUT1: begin
                w_out_valid = 1'b1;
                w_out       = r_x1;
            end
            default: ;
        endcase
    end

    // Word counter and singular flag; a 2- or 3-word fall leaves the flag untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_singular <= 1'b0;
        end else if (w_mat_start) begin
            r_cnt <= 3'd1;
        end else if (r_state == LOAD_M) begin
            if (MAT_VALID) begin
                if (r_cnt < 3'd4) r_cnt <= r_cnt + 3'd1;
            end else if (r_cnt == 3'd1) begin
                r_singular <= 1'b1;
            end else if (r_cnt == 3'd4) begin
                r_singular <= 1'b0;
            end
        end
    end

    // NOTE: datapath storage has no reset; it is always written before the FSM reads it.
    always_ff @(posedge clk) begin
        if (w_mat_start)
            r_mat[0] <= MAT;
        else if (r_state == LOAD_M && MAT_VALID && r_cnt < 3'd4)
            r_mat[r_cnt[1:0]] <= MAT;
        if (r_state == WAIT_V && w_next == LOAD_V) r_v0 <= VEC;
        if (r_state == LOAD_V) r_v1 <= VEC;
        if (r_state == CALC) begin
            r_x0 <= w_dot0;
            r_x1 <= w_dot1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_singular_out <= 1'b0;
            r_out          <= '0;
        end else begin
            r_out_valid    <= w_out_valid;
            r_singular_out <= w_singular;
            r_out          <= w_out;
        end
    end

    inv_solver_mac u_row0 (
        .i_m0  (r_mat[0]),
        .i_m1  (r_mat[1]),
        .i_v0  (r_v0),
        .i_v1  (r_v1),
        .o_dot (w_dot0)
    );

    inv_solver_mac u_row1 (
        .i_m0  (r_mat[2]),
        .i_m1  (r_mat[3]),
        .i_v0  (r_v0),
        .i_v1  (r_v1),
        .o_dot (w_dot1)
    );

    assign OUT_VALID = r_out_valid;
    assign OUT       = r_out;
    assign SINGULAR  = r_singular_out;

endmodule
